mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Parametrised N-port round-robin arbiter that merges several requester-side memory buses (mem_in_type / mem_out_type valid/ready protocol) onto one downstream memory port. It sits between the core's fetch and load/store paths (and later DMA or debug masters) and the single memory or bus bridge. It generalises the current fixed instruction/data split to NUM_PORTS requesters. It registers the granted request and allows exactly one transaction outstanding downstream.

Parameters:
NUM_PORTS, 2, number of requester ports; legal range 2..16.
TIMEOUT, 1023, downstream wait limit in cycles; used only when the optional feature is compiled in.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
m_in  in  NUM_PORTS x mem_in_type  requester requests; index i is port i.
m_out  out  NUM_PORTS x mem_out_type  per-port ready and read data.
m_err  out  NUM_PORTS  per-port error strobe; asserted with mem_ready.
s_in  out  mem_in_type  downstream request.
s_out  in  mem_out_type  downstream response.

Behaviour:
- Requester protocol: hold mem_valid and all request fields stable until mem_ready is sampled high; valid may change only at the edge following ready.
- State machine:
  - IDLE
    - If any m_in[i].mem_valid is high: select a winner, latch its request into the s_in register, record grant index g, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY
    - s_in.mem_valid=1, all fields held constant.
    - When s_out.mem_ready=1: latch s_out.mem_rdata, drop s_in.mem_valid at that edge, go to RESP.
  - RESP (exactly 1 cycle)
    - m_out[g].mem_ready=1, m_out[g].mem_rdata = latched data.
    - No arbitration in this cycle, so the requester's still-high valid cannot be re-granted. Next state is IDLE.
- Latency with a zero-wait slave: request seen in cycle 0; s_in valid in cycle 1; ready to requester in cycle 2; next grant possible from cycle 3.
- Round-robin:
  - Priority pointer p is the highest-priority port; search order is p, p+1, ... wrapping modulo NUM_PORTS.
  - On each grant, p <= (g+1) mod NUM_PORTS. After reset p=0.
  - Wrap case: with NUM_PORTS=4 and g=3, p becomes 0.
- Non-granted ports: mem_ready=0, mem_rdata=0, m_err=0 at all times.
- Reset values:
  - state=IDLE, p=0, g=0.
  - s_in all fields 0.
  - every m_out ready=0 and rdata=0; m_err all 0.
- Reset mid-transaction: return to IDLE next cycle, s_in.mem_valid=0, the pending transaction is discarded with no ready issued. The downstream slave shares the same reset.
- A requester deasserting valid while granted is a protocol violation; the arbiter completes the transaction anyway.

Optional Feature:
MEM_ARBITER_TIMEOUT_EN
- Defined:
  - A counter with $clog2(TIMEOUT+1) bits clears on entry to BUSY and increments each BUSY cycle without ready.
  - On the cycle the count equals TIMEOUT, s_in.mem_valid drops at the next edge and the FSM goes to RESP with rdata=0 and m_err[g]=1 alongside mem_ready.
  - A ready arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter exists, BUSY waits indefinitely, and m_err is tied to 0.

Decomposition:
- Additions to package wires:
  - mem_arb_state_type, an enum of IDLE, BUSY, RESP.
  - mem_arb_reg_type, a struct holding state, pointer, grant, latched request, rdata, count and err.
  - init_mem_arb_reg, its reset constant.
- One combinational sub-module, arbiter_priority:
  - Inputs: NUM_PORTS request bits and the pointer.
  - Outputs: grant index and a found flag.
  - Implementation: rotate, find-first, un-rotate.

Test Plan:
1. Reset, then m_in[0] read at 0x100; slave ready in the same cycle with rdata 0xDEADBEEF -> s_in.mem_valid high only in cycle 1 with addr 0x100; m_out[0].mem_ready=1, rdata=0xDEADBEEF only in cycle 2; m_out[1] stays 0.
2. After reset, ports 0 and 1 request simultaneously -> port 0 served first, port 1 granted in the cycle after port 0's RESP.
3. NUM_PORTS=4, all ports requesting continuously -> grant order 0,1,2,3,0,1, with p wrapping 3->0.
4. Port 1 write of 0xA5A5A5A5 with wstrb 4'b0011; slave waits 5 cycles -> s_in fields stable for all 6 BUSY cycles; exactly one ready pulse to port 1.
5. reset asserted during BUSY -> next cycle s_in.mem_valid=0, no m_out ready; a fresh request after reset is served normally from p=0.
6. With MEM_ARBITER_TIMEOUT_EN and TIMEOUT=8, slave never ready -> s_in.mem_valid drops after the 8-cycle limit; m_out[g].mem_ready=1, m_err[g]=1, rdata=0; without the macro, valid stays high for 100+ cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared bus structs, arbiter FSM state and register record for mem_arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int MEM_ARB_MAX_PORTS = 16;
    localparam int MEM_ARB_IDX_W     = 4;   // enough to index MEM_ARB_MAX_PORTS requesters
    localparam int MEM_ARB_CNT_W     = 16;  // upper bound on the timeout counter width

    // Requester -> memory request; a write is any request with nonzero wstrb
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    // Memory -> requester response
    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_arb_state_type;

    // Complete arbiter state; the downstream request is driven straight from req
    typedef struct packed {
        mem_arb_state_type          state;
        logic [MEM_ARB_IDX_W-1:0]   pointer;
        logic [MEM_ARB_IDX_W-1:0]   grant;
        mem_in_type                 req;
        logic [31:0]                rdata;
        logic [MEM_ARB_CNT_W-1:0]   count;
        logic                       err;
    } mem_arb_reg_type;

    localparam mem_arb_reg_type init_mem_arb_reg = '{
        state:   IDLE,
        pointer: '0,
        grant:   '0,
        req:     '0,
        rdata:   '0,
        count:   '0,
        err:     1'b0
    };

    // Port after g in round-robin order, wrapping to 0 after the last port
    function automatic logic [MEM_ARB_IDX_W-1:0] next_pointer(
        input logic [MEM_ARB_IDX_W-1:0] g,
        input int                       num_ports
    );
        if (int'(g) >= num_ports - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_priority.sv
// Purpose: round-robin pick of the first requesting port at or after pointer.
// Latency: purely combinational.
// Backpressure: none; found is low when no port requests.
module arbiter_priority
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
)(
    input  logic [NUM_PORTS-1:0]     req,
    input  logic [MEM_ARB_IDX_W-1:0] pointer,
    output logic [MEM_ARB_IDX_W-1:0] grant,
    output logic                     found
);

    logic [NUM_PORTS-1:0] rotated;
    int                   first;

    // a + b wrapped into 0..NUM_PORTS-1 (both operands are already in range)
    function automatic int wrap_add(input int a, input int b);
        int s;
        s = a + b;
        return (s >= NUM_PORTS) ? s - NUM_PORTS : s;
    endfunction

    // Rotate the request vector so the pointer's port lands on bit 0
    always_comb begin
        rotated = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (j == wrap_add(i, int'(pointer))) begin
                    rotated[i] = req[j];
                end
            end
        end
    end

    // Find the lowest set bit of the rotated vector
    always_comb begin
        found = 1'b0;
        first = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found = 1'b1;
                first = i;
            end
        end
    end

    // Undo the rotation to recover the real port index
    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (j == wrap_add(first, int'(pointer))) begin
                grant = MEM_ARB_IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: N-port round-robin merge of requester memory buses onto one downstream port (MEM_ARBITER_TIMEOUT_EN adds a downstream wait limit).
// Latency: zero-wait slave gives s_in valid 1 cycle after request, requester ready after 2, next grant after 3.
// Backpressure: one downstream transaction outstanding; other requesters hold valid until granted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT   = 1023
)(
    input  logic                        clock,
    input  logic                        reset,
    input  mem_in_type  [NUM_PORTS-1:0] m_in,
    output mem_out_type [NUM_PORTS-1:0] m_out,
    output logic        [NUM_PORTS-1:0] m_err,
    output mem_in_type                  s_in,
    input  mem_out_type                 s_out
);

    if (NUM_PORTS < 2 || NUM_PORTS > MEM_ARB_MAX_PORTS ||
        TIMEOUT < 1 || TIMEOUT >= (1 << MEM_ARB_CNT_W)) begin : g_bad_params
        $error("mem_arbiter: NUM_PORTS or TIMEOUT out of range");
    end

    mem_arb_reg_type          r;
    mem_arb_reg_type          rin;
    logic [NUM_PORTS-1:0]     req_bits;
    logic [MEM_ARB_IDX_W-1:0] win_idx;
    logic                     win_found;

    // Collect the valid bits for the priority picker
    always_comb begin
        req_bits = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_bits[i] = m_in[i].mem_valid;
        end
    end

    arbiter_priority #(
        .NUM_PORTS (NUM_PORTS)
    ) u_priority (
        .req     (req_bits),
        .pointer (r.pointer),
        .grant   (win_idx),
        .found   (win_found)
    );

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r <= init_mem_arb_reg;
        end else begin
            r <= rin;
        end
    end

    // Next-state: grant in IDLE, wait in BUSY, one ready cycle in RESP
    always_comb begin
        mem_arb_reg_type v;
        v = r;
        case (r.state)
            IDLE: begin
                if (win_found) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (win_idx == MEM_ARB_IDX_W'(i)) begin
                            v.req = m_in[i];
                        end
                    end
                    v.req.mem_valid = 1'b1;
                    v.grant         = win_idx;
                    v.pointer       = next_pointer(win_idx, NUM_PORTS);
                    v.count         = '0;
                    v.err           = 1'b0;
                    v.state         = BUSY;
                end
            end
            BUSY: begin
                // A ready in the timeout cycle still counts as a normal completion
                if (s_out.mem_ready) begin
                    v.rdata         = s_out.mem_rdata;
                    v.req.mem_valid = 1'b0;
                    v.err           = 1'b0;
                    v.state         = RESP;
                end
`ifdef MEM_ARBITER_TIMEOUT_EN
                // Count never exceeds TIMEOUT, so only its low $clog2(TIMEOUT+1) bits toggle
                else if (r.count == MEM_ARB_CNT_W'(TIMEOUT)) begin
                    v.rdata         = '0;
                    v.req.mem_valid = 1'b0;
                    v.err           = 1'b1;
                    v.state         = RESP;
                end else begin
                    v.count = r.count + 1'b1;
                end
`endif
            end
            // No arbitration here, so the finishing requester's valid is not re-granted
            RESP: begin
                v.state = IDLE;
            end
            default: begin
                v.state = IDLE;
            end
        endcase
        rin = v;
    end

    assign s_in = r.req;

    // Only the granted port sees ready/data/error, and only during RESP
    always_comb begin
        m_out = '0;
        m_err = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r.state == RESP && r.grant == MEM_ARB_IDX_W'(i)) begin
                m_out[i].mem_ready = 1'b1;
                m_out[i].mem_rdata = r.rdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
                m_err[i] = r.err;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with directed steps and a randomized round-robin phase.
// Latency: expectations follow the 1-cycle grant / 1-cycle response timing of the arbiter.
// Backpressure: bench slave inserts random wait states; requesters hold requests until ready.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int TO = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    mem_in_type  [NP-1:0] m_in;
    mem_out_type [NP-1:0] m_out;
    logic        [NP-1:0] m_err;
    mem_in_type           s_in;
    mem_out_type          s_out;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mem_arbiter #(
        .NUM_PORTS (NP),
        .TIMEOUT   (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .m_in  (m_in),
        .m_out (m_out),
        .m_err (m_err),
        .s_in  (s_in),
        .s_out (s_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mem_in_type mk_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_in_type q;
        q = '0;
        q.mem_valid = 1'b1;
        q.mem_addr  = a;
        q.mem_wdata = d;
        q.mem_wstrb = s;
        return q;
    endfunction

    // Reference round-robin: first requesting port scanning p, p+1, ... modulo NP
    function automatic int pick(input logic [NP-1:0] mask, input int p);
        for (int k = 0; k < NP; k++) begin
            if (mask[(p + k) % NP]) return (p + k) % NP;
        end
        return -1;
    endfunction

    initial begin
        logic [NP-1:0] pend;
        logic [NP-1:0] mask_prev;
        mem_in_type    rq [NP];
        mem_out_type   exp_o;
        logic          prev_sv;
        logic          resp_due;
        logic          sv;
        logic          got;
        logic [31:0]   exp_rdata;
        int            p;
        int            cur;
        int            w;
        int            wait_cnt;
        int            stall;
        int            hi_cnt;
        int            order [6];

        order = '{0, 1, 2, 3, 0, 1};
        reset = 1'b1;
        m_in  = '0;
        s_out = '0;
        tick();
        tick();

        // Reset state
        chk("rst_s_in", 160'(s_in), 160'(0));
        chk("rst_m_out", 160'(m_out), 160'(0));
        chk("rst_m_err", 160'(m_err), 160'(0));

        // Single read with a zero-wait slave
        reset   = 1'b0;
        m_in[0] = mk_req(32'h100, 32'h0, 4'h0);
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'hDEADBEEF;
        chk("t1_c0_valid", 160'(s_in.mem_valid), 160'(0));
        tick();
        chk("t1_c1_valid", 160'(s_in.mem_valid), 160'(1));
        chk("t1_c1_addr", 160'(s_in.mem_addr), 160'(32'h100));
        chk("t1_c1_m_out", 160'(m_out), 160'(0));
        tick();
        chk("t1_c2_valid", 160'(s_in.mem_valid), 160'(0));
        chk("t1_c2_ready0", 160'(m_out[0].mem_ready), 160'(1));
        chk("t1_c2_rdata0", 160'(m_out[0].mem_rdata), 160'(32'hDEADBEEF));
        chk("t1_c2_port1", 160'(m_out[1]), 160'(0));
        m_in  = '0;
        s_out = '0;
        tick();
        chk("t1_c3_ready0", 160'(m_out[0].mem_ready), 160'(0));

        // Two simultaneous requesters after reset: port 0 first, port 1 right after
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_in[0] = mk_req(32'h110, 32'h0, 4'h0);
        m_in[1] = mk_req(32'h120, 32'h0, 4'h0);
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'h11111111;
        tick();
        chk("t2_first_addr", 160'(s_in.mem_addr), 160'(32'h110));
        tick();
        chk("t2_ready0", 160'(m_out[0].mem_ready), 160'(1));
        chk("t2_ready1_early", 160'(m_out[1].mem_ready), 160'(0));
        m_in[0] = '0;
        tick();
        chk("t2_idle_valid", 160'(s_in.mem_valid), 160'(0));
        tick();
        chk("t2_second_valid", 160'(s_in.mem_valid), 160'(1));
        chk("t2_second_addr", 160'(s_in.mem_addr), 160'(32'h120));
        tick();
        chk("t2_ready1", 160'(m_out[1].mem_ready), 160'(1));
        chk("t2_rdata1", 160'(m_out[1].mem_rdata), 160'(32'h11111111));
        m_in  = '0;
        s_out = '0;
        tick();

        // All four ports requesting continuously: 0,1,2,3,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NP; i++) m_in[i] = mk_req(32'h1000 + 32'(16 * i), 32'h0, 4'h0);
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'h55550000;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3_order_addr", 160'(s_in.mem_addr), 160'(32'h1000 + 32'(16 * order[k])));
            tick();
            chk("t3_order_ready", 160'(m_out[order[k]].mem_ready), 160'(1));
            if (k == 5) begin
                m_in  = '0;
                s_out = '0;
            end
            tick();
        end

        // Write from port 1 with 5 wait states: fields stable for 6 BUSY cycles
        m_in[1] = mk_req(32'h200, 32'hA5A5A5A5, 4'b0011);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("t4_s_in_stable", 160'(s_in), 160'(mk_req(32'h200, 32'hA5A5A5A5, 4'b0011)));
            chk("t4_no_early_ready", 160'(m_out[1].mem_ready), 160'(0));
        end
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'h0BADF00D;
        tick();
        chk("t4_ready1", 160'(m_out[1].mem_ready), 160'(1));
        chk("t4_rdata1", 160'(m_out[1].mem_rdata), 160'(32'h0BADF00D));
        chk("t4_valid_drop", 160'(s_in.mem_valid), 160'(0));
        m_in  = '0;
        s_out = '0;
        tick();
        chk("t4_single_pulse", 160'(m_out[1].mem_ready), 160'(0));

        // Reset during BUSY discards the transaction; pointer restarts at 0
        m_in[2] = mk_req(32'h400, 32'h0, 4'h0);
        tick();
        chk("t5_busy_valid", 160'(s_in.mem_valid), 160'(1));
        reset = 1'b1;
        m_in  = '0;
        tick();
        chk("t5_rst_valid", 160'(s_in.mem_valid), 160'(0));
        chk("t5_rst_m_out", 160'(m_out), 160'(0));
        reset   = 1'b0;
        m_in[3] = mk_req(32'h430, 32'h0, 4'h0);
        m_in[0] = mk_req(32'h400, 32'h0, 4'h0);
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'h77778888;
        tick();
        chk("t5_after_rst_addr", 160'(s_in.mem_addr), 160'(32'h400));
        tick();
        chk("t5_ready0", 160'(m_out[0].mem_ready), 160'(1));
        m_in[0] = '0;
        tick();
        tick();
        chk("t5_next_addr", 160'(s_in.mem_addr), 160'(32'h430));
        tick();
        chk("t5_ready3", 160'(m_out[3].mem_ready), 160'(1));
        m_in  = '0;
        s_out = '0;
        tick();

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Slave never answers: error completion after TIMEOUT+1 BUSY cycles
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_in[0] = mk_req(32'h300, 32'h0, 4'h0);
        hi_cnt  = 0;
        got     = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (m_out[0].mem_ready) begin
                got = 1'b1;
                chk("to_err", 160'(m_err[0]), 160'(1));
                chk("to_rdata", 160'(m_out[0].mem_rdata), 160'(0));
                chk("to_valid_drop", 160'(s_in.mem_valid), 160'(0));
            end else if (s_in.mem_valid) begin
                hi_cnt++;
            end
        end
        chk("to_seen", 160'(got), 160'(1));
        chk("to_busy_cycles", 160'(hi_cnt), 160'(TO + 1));
        m_in = '0;
        tick();

        // Ready arriving on the timeout cycle completes normally
        m_in[1] = mk_req(32'h304, 32'h0, 4'h0);
        for (int c = 1; c <= TO + 1; c++) tick();
        chk("to_race_valid", 160'(s_in.mem_valid), 160'(1));
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'hCAFEF00D;
        tick();
        chk("to_race_ready", 160'(m_out[1].mem_ready), 160'(1));
        chk("to_race_rdata", 160'(m_out[1].mem_rdata), 160'(32'hCAFEF00D));
        chk("to_race_err", 160'(m_err[1]), 160'(0));
        m_in  = '0;
        s_out = '0;
        tick();
`else
        // No timeout: the request is held for as long as the slave stalls
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_in[0] = mk_req(32'h300, 32'h0, 4'h0);
        hi_cnt  = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (s_in.mem_valid) hi_cnt++;
        end
        chk("nto_held", 160'(hi_cnt), 160'(120));
        chk("nto_no_ready", 160'(m_out), 160'(0));
        s_out.mem_ready = 1'b1;
        s_out.mem_rdata = 32'h12345678;
        tick();
        chk("nto_ready", 160'(m_out[0].mem_ready), 160'(1));
        chk("nto_rdata", 160'(m_out[0].mem_rdata), 160'(32'h12345678));
        chk("nto_err", 160'(m_err), 160'(0));
        m_in  = '0;
        s_out = '0;
        tick();
`endif

        // Randomized requesters and slave wait states against the round-robin model
        reset = 1'b1;
        m_in  = '0;
        s_out = '0;
        tick();
        reset     = 1'b0;
        pend      = '0;
        mask_prev = '0;
        p         = 0;
        cur       = 0;
        prev_sv   = 1'b0;
        resp_due  = 1'b0;
        wait_cnt  = 0;
        stall     = 0;
        exp_rdata = '0;
        for (int i = 0; i < NP; i++) rq[i] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            sv = s_in.mem_valid;
            // New downstream request: must be the model's round-robin winner
            if (sv && !prev_sv) begin
                w = pick(mask_prev, p);
                chk("rr_grant_found", 160'(w >= 0), 160'(1));
                if (w >= 0) begin
                    chk("rr_grant_req", 160'(s_in), 160'(rq[w]));
                    p   = (w + 1) % NP;
                    cur = w;
                end
                wait_cnt = $urandom_range(0, 3);
            end
            for (int i = 0; i < NP; i++) begin
                exp_o = '0;
                if (resp_due && i == cur) begin
                    exp_o.mem_ready = 1'b1;
                    exp_o.mem_rdata = exp_rdata;
                end
                chk("rr_port_out", 160'(m_out[i]), 160'(exp_o));
                chk("rr_port_err", 160'(m_err[i]), 160'(0));
            end
            if (resp_due) begin
                chk("rr_valid_drop", 160'(sv), 160'(0));
                pend[cur] = 1'b0;
            end
            resp_due = 1'b0;
            if (pend != '0 && !sv) stall++;
            else stall = 0;
            chk("rr_liveness", 160'(stall <= 2), 160'(1));
            // Slave: answer after the chosen number of wait states
            if (sv) begin
                if (wait_cnt == 0) begin
                    exp_rdata       = $urandom;
                    s_out.mem_ready = 1'b1;
                    s_out.mem_rdata = exp_rdata;
                    resp_due        = 1'b1;
                end else begin
                    wait_cnt--;
                    s_out.mem_ready = 1'b0;
                end
            end else begin
                s_out.mem_ready = 1'b0;
            end
            // Requesters: idle ports randomly raise a new request
            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    rq[i]   = mk_req(($urandom & 32'hFFFFFF0F) | (32'(i) << 4), $urandom, 4'($urandom));
                    pend[i] = 1'b1;
                end
                m_in[i] = pend[i] ? rq[i] : '0;
            end
            mask_prev = pend;
            prev_sv   = sv;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
